ex_stage: RTL and testbench

- Execute stage of the 5-stage integer pipeline, directly downstream of the forwarding/hazard select unit.
- Consumes A_select, B_select and stall from that unit, plus the ID/EX latch contents.
- Muxes forwarded operands, runs the ALU, and registers the results into the EX/MEM latch.
- EX_MEM_IR produced here feeds back into the select unit.

---
 rtl/pipe_defs_pkg.sv | 25 ++
 rtl/ex_alu.sv | 46 ++++
 rtl/ex_stage.sv | 108 ++++++++++
 tb/tb_ex_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_defs_pkg.sv
// rtl/pipe_defs_pkg.sv - opcode, funct and forwarding-select encodings shared by the EX stage
package pipe_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    SEL_REG       = 3'b000,
    SEL_BASE_IMM  = 3'b001,
    SEL_EXMEM_ALU = 3'b010,
    SEL_MEMWB_ALU = 3'b011,
    SEL_MEMWB_LMD = 3'b100
  } sel_e;

  localparam logic [31:0] NOP_IR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational ALU; R-type ops by funct, plain add for address generation
// Overflow detection is built only when EX_OVERFLOW_EN is defined.
module ex_alu
  import pipe_defs_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [5:0]   funct,
  input  logic         is_rtype,
  output logic [W-1:0] result,
  output logic         ovf
);

  always_comb begin
    result = '0;
    if (!is_rtype) begin
      result = a + b;
    end else begin
      case (funct)
        FN_ADD:  result = a + b;
        FN_SUB:  result = a - b;
        FN_AND:  result = a & b;
        FN_OR:   result = a | b;
        FN_XOR:  result = a ^ b;
        FN_SLT:  result = ($signed(a) < $signed(b)) ? W'(1) : '0;
        default: result = '0;
      endcase
    end
  end

`ifdef EX_OVERFLOW_EN
  // Sub overflows when operand signs differ and the result sign leaves a's sign.
  always_comb begin
    ovf = 1'b0;
    if (is_rtype && funct == FN_ADD)
      ovf = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
    else if (is_rtype && funct == FN_SUB)
      ovf = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding muxes, ALU and EX/MEM latch
// Optional signed-overflow flag enabled by EX_OVERFLOW_EN.
module ex_stage
  import pipe_defs_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_IR = NOP_IR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        A_select,
  input  logic [2:0]        B_select,
  input  logic [DATA_W-1:0] ID_EX_IR,
  input  logic [DATA_W-1:0] ID_EX_A,
  input  logic [DATA_W-1:0] ID_EX_B,
  input  logic [DATA_W-1:0] ID_EX_Imm,
  input  logic [DATA_W-1:0] EX_MEM_ALUo_fwd,
  input  logic [DATA_W-1:0] MEM_WB_ALUo,
  input  logic [DATA_W-1:0] MEM_WB_LMD,
  output logic [DATA_W-1:0] EX_MEM_IR,
  output logic [DATA_W-1:0] EX_MEM_ALUo,
  output logic [DATA_W-1:0] EX_MEM_B,
  output logic              EX_MEM_valid,
  output logic              EX_MEM_ovf
);

  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic              alu_ovf, is_rtype, is_mem;
  logic [5:0]        opcode;

  logic [DATA_W-1:0] ir_d, ir_q, alu_d, alu_q, b_d, b_q;
  logic              valid_d, valid_q, ovf_d, ovf_q;

  assign opcode   = ID_EX_IR[DATA_W-1 -: 6];
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);

  always_comb begin
    fwd_a = ID_EX_A;
    case (A_select)
      SEL_EXMEM_ALU: fwd_a = EX_MEM_ALUo_fwd;
      SEL_MEMWB_ALU: fwd_a = MEM_WB_ALUo;
      SEL_MEMWB_LMD: fwd_a = MEM_WB_LMD;
      default:       fwd_a = ID_EX_A;
    endcase
  end

  always_comb begin
    fwd_b = ID_EX_B;
    case (B_select)
      SEL_EXMEM_ALU: fwd_b = EX_MEM_ALUo_fwd;
      SEL_MEMWB_ALU: fwd_b = MEM_WB_ALUo;
      SEL_MEMWB_LMD: fwd_b = MEM_WB_LMD;
      default:       fwd_b = ID_EX_B;
    endcase
  end

  // Loads/stores use the immediate on the ALU; forwarded B only reaches memory as store data.
  assign alu_b = is_rtype ? fwd_b : ID_EX_Imm;

  ex_alu #(.W(DATA_W)) u_alu (
    .a        (fwd_a),
    .b        (alu_b),
    .funct    (ID_EX_IR[5:0]),
    .is_rtype (is_rtype),
    .result   (alu_res),
    .ovf      (alu_ovf)
  );

  always_comb begin
    ir_d    = ID_EX_IR;
    valid_d = 1'b1;
    alu_d   = (is_rtype || is_mem) ? alu_res : '0;
    b_d     = (is_rtype || is_mem) ? fwd_b : ID_EX_B;
    ovf_d   = alu_ovf;
    if (stall) begin
      ir_d    = NOP_IR;
      valid_d = 1'b0;
      alu_d   = '0;
      b_d     = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q    <= NOP_IR;
      alu_q   <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign EX_MEM_IR    = ir_q;
  assign EX_MEM_ALUo  = alu_q;
  assign EX_MEM_B     = b_q;
  assign EX_MEM_valid = valid_q;
  assign EX_MEM_ovf   = ovf_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage: directed cases plus randomized model comparison
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [2:0]  A_select, B_select;
  logic [31:0] ID_EX_IR, ID_EX_A, ID_EX_B, ID_EX_Imm;
  logic [31:0] EX_MEM_ALUo_fwd, MEM_WB_ALUo, MEM_WB_LMD;
  logic [31:0] EX_MEM_IR, EX_MEM_ALUo, EX_MEM_B;
  logic        EX_MEM_valid, EX_MEM_ovf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] b;
    logic        valid;
    logic        ovf;
  } exp_t;

  exp_t e;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .A_select(A_select), .B_select(B_select),
    .ID_EX_IR(ID_EX_IR), .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_Imm(ID_EX_Imm),
    .EX_MEM_ALUo_fwd(EX_MEM_ALUo_fwd), .MEM_WB_ALUo(MEM_WB_ALUo), .MEM_WB_LMD(MEM_WB_LMD),
    .EX_MEM_IR(EX_MEM_IR), .EX_MEM_ALUo(EX_MEM_ALUo), .EX_MEM_B(EX_MEM_B),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_ovf(EX_MEM_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t x);
    check({tag, ".ir"},    EX_MEM_IR,           x.ir);
    check({tag, ".alu"},   EX_MEM_ALUo,         x.alu);
    check({tag, ".b"},     EX_MEM_B,            x.b);
    check({tag, ".valid"}, {31'b0, EX_MEM_valid}, {31'b0, x.valid});
    check({tag, ".ovf"},   {31'b0, EX_MEM_ovf},   {31'b0, x.ovf});
  endtask

  function automatic logic [31:0] pick(input int sel, input logic [31:0] reg_v);
    if (sel == 2) return EX_MEM_ALUo_fwd;
    if (sel == 3) return MEM_WB_ALUo;
    if (sel == 4) return MEM_WB_LMD;
    return reg_v;
  endfunction

  // Reference: arithmetic done on wide signed integers, overflow from range check.
  function automatic exp_t model();
    exp_t r;
    longint sa, sb, s;
    logic [31:0] fa, fb;
    int op, fn;
    r.ir = ID_EX_IR; r.valid = 1'b1; r.ovf = 1'b0; r.alu = 32'd0; r.b = ID_EX_B;
    if (stall) begin
      r.ir = 32'd0; r.valid = 1'b0; r.b = 32'd0;
      return r;
    end
    fa = pick(int'(A_select), ID_EX_A);
    fb = pick(int'(B_select), ID_EX_B);
    op = int'(ID_EX_IR[31:26]);
    fn = int'(ID_EX_IR[5:0]);
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    if (op == 0) begin
      r.b = fb;
      s = 0;
      case (fn)
        32: begin s = sa + sb; r.alu = s[31:0]; end
        34: begin s = sa - sb; r.alu = s[31:0]; end
        36: r.alu = fa & fb;
        37: r.alu = fa | fb;
        38: r.alu = fa ^ fb;
        42: r.alu = (sa < sb) ? 32'd1 : 32'd0;
        default: r.alu = 32'd0;
      endcase
`ifdef EX_OVERFLOW_EN
      if ((fn == 32 || fn == 34) && (s > 64'sd2147483647 || s < -64'sd2147483648)) r.ovf = 1'b1;
`endif
    end else if (op == 35 || op == 43) begin
      r.alu = 32'(longint'(fa) + longint'(ID_EX_Imm));
      r.b = fb;
    end
    return r;
  endfunction

  task automatic step(input string tag);
    exp_t x;
    x = model();
    @(posedge clk);
    #1;
    check_all(tag, x);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ir, input logic [2:0] as, input logic [2:0] bs,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    ID_EX_IR = ir; A_select = as; B_select = bs;
    ID_EX_A = a; ID_EX_B = b; ID_EX_Imm = imm;
  endtask

  initial begin
    logic [5:0] ops [4];
    logic [5:0] fns [7];
    logic [31:0] ir;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h0D};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h07};

    rst = 1'b1; stall = 1'b0;
    drive(32'h0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    EX_MEM_ALUo_fwd = 32'h0; MEM_WB_ALUo = 32'h0; MEM_WB_LMD = 32'h0;
    #12;
    e = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    check_all("reset", e);
    @(negedge clk);
    rst = 1'b0;

    drive({6'h00, 20'h12345, 6'h20}, 3'd0, 3'd0, 32'd5, 32'd7, 32'h0);
    step("add");
    check("add.alu12", EX_MEM_ALUo, 32'd12);

    // async reset mid-cycle while the add sits in EX/MEM
    #2 rst = 1'b1;
    #1;
    e = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    check_all("async_rst", e);
    @(negedge clk);
    rst = 1'b0;

    EX_MEM_ALUo_fwd = 32'd20; MEM_WB_LMD = 32'd3;
    drive({6'h00, 20'h0, 6'h22}, 3'd2, 3'd4, 32'd99, 32'd98, 32'h0);
    step("fwd_sub");
    check("fwd_sub.alu17", EX_MEM_ALUo, 32'd17);

    MEM_WB_ALUo = 32'hAB;
    drive({6'h2B, 26'h0}, 3'd1, 3'd3, 32'h100, 32'h55, 32'hFFFF_FFFC);
    step("sw");
    check("sw.alu", EX_MEM_ALUo, 32'hFC);
    check("sw.b", EX_MEM_B, 32'hAB);

    drive({6'h23, 26'h1}, 3'd0, 3'd0, 32'h200, 32'h9, 32'h10);
    stall = 1'b1;
    step("stall");
    step("stall2");
    stall = 1'b0;
    step("lw_after_stall");
    check("lw.alu", EX_MEM_ALUo, 32'h210);

    drive({6'h00, 20'h0, 6'h20}, 3'd0, 3'd0, 32'h7FFF_FFFF, 32'd1, 32'h0);
    step("add_ovf");
    check("add_ovf.alu", EX_MEM_ALUo, 32'h8000_0000);
`ifdef EX_OVERFLOW_EN
    check("add_ovf.flag", {31'b0, EX_MEM_ovf}, 32'd1);
`else
    check("add_ovf.flag", {31'b0, EX_MEM_ovf}, 32'd0);
`endif

    drive({6'h0D, 26'h3ABCDE}, 3'd2, 3'd2, 32'h1, 32'h77, 32'h5);
    step("other_op");
    drive({6'h00, 20'h0, 6'h2A}, 3'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0);
    step("slt_neg");
    check("slt_neg.alu", EX_MEM_ALUo, 32'd1);

    for (int i = 0; i < 300; i++) begin
      ir = $urandom;
      ir[31:26] = ops[$urandom_range(0, 3)];
      if (ir[31:26] == 6'h00) ir[5:0] = fns[$urandom_range(0, 6)];
      EX_MEM_ALUo_fwd = $urandom; MEM_WB_ALUo = $urandom; MEM_WB_LMD = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        drive(ir, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'h7FFF_FFF0 + 31'($urandom_range(0, 31))},
              {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'h7FFF_FFF0 + 31'($urandom_range(0, 31))},
              $urandom);
      end else begin
        drive(ir, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      end
      stall = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
